// File: rtl/pipeline_core_param_if.sv
// Instruction-memory write port and debug register-file read port of pipeline_core_param.
interface pipeline_core_param_if #(
    parameter int AW     = 6,
    parameter int DATA_W = 16
);
    logic              imem_we;
    logic [AW-1:0]     imem_waddr;
    logic [15:0]       imem_wdata;
    logic [2:0]        dbg_raddr;
    logic [DATA_W-1:0] dbg_rdata;

    modport master (output imem_we, imem_waddr, imem_wdata, dbg_raddr, input dbg_rdata);
    modport slave  (input imem_we, imem_waddr, imem_wdata, dbg_raddr, output dbg_rdata);
endinterface

// File: rtl/pipeline_core_param.sv
// Four-stage (IF/ID/EX/WB) in-order core with loadable instruction memory, 8-entry register
// file, build-time EX forwarding or RAW interlock, run/halt control and retired counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | after reset; imem writable, waiting for run
// ST_RUN  | fetching and executing; imem writes and run ignored
// ST_HALTED | HLT left WB; imem writable, run restarts from pc=0
module pipeline_core_param #(
    parameter int DATA_W     = 16,
    parameter int IMEM_DEPTH = 64,
    parameter int FWD_EN     = 1,
    localparam int AW        = $clog2(IMEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    pipeline_core_param_if.slave bus,
    output logic [DATA_W-1:0]    result,
    output logic                 result_valid,
    output logic                 halted,
    output logic [AW-1:0]        pc,
    output logic [15:0]          retired
);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   start;

    logic [15:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] regs [8];

    logic              ifid_valid;
    logic [15:0]       ifid_instr;
    logic              fetch_stop;

    logic              idex_valid, idex_we;
    logic [3:0]        idex_op;
    logic [2:0]        idex_rd, idex_rs, idex_rt;
    logic [DATA_W-1:0] idex_a, idex_b, idex_imm;

    logic              exwb_valid, exwb_we, exwb_hlt;
    logic [2:0]        exwb_rd;
    logic [DATA_W-1:0] exwb_data;

    function automatic logic op_uses_rs(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
               (op == OP_NOT) || (op == OP_MOV) || (op == OP_ADDI);
    endfunction

    function automatic logic op_uses_rt(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic op_writes(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_ADDI);
    endfunction

    logic [15:0]       fetch_word;
    logic              fetch_hlt;
    logic [3:0]        id_op;
    logic [2:0]        id_rd, id_rs, id_rt;
    logic [DATA_W-1:0] id_imm, id_a, id_b;
    logic              wb_wr, raw_hit, stall;
    logic [DATA_W-1:0] ex_a, ex_b, ex_res;

    assign fetch_word = imem[pc];
    assign fetch_hlt  = (fetch_word[15:12] == OP_HLT);

    assign id_op  = ifid_instr[15:12];
    assign id_rd  = ifid_instr[11:9];
    assign id_rs  = ifid_instr[8:6];
    assign id_rt  = ifid_instr[5:3];
    assign id_imm = {{(DATA_W-6){ifid_instr[5]}}, ifid_instr[5:0]};

    // Register-file write-through: the value being written this edge is seen by ID.
    assign wb_wr = exwb_valid && exwb_we;
    assign id_a  = (wb_wr && exwb_rd == id_rs) ? exwb_data : regs[id_rs];
    assign id_b  = (wb_wr && exwb_rd == id_rt) ? exwb_data : regs[id_rt];

    assign raw_hit = ifid_valid && idex_valid && idex_we &&
                     ((op_uses_rs(id_op) && idex_rd == id_rs) ||
                      (op_uses_rt(id_op) && idex_rd == id_rt));
    assign stall   = (FWD_EN == 0) && raw_hit;

    assign ex_a = (FWD_EN != 0 && wb_wr && exwb_rd == idex_rs) ? exwb_data : idex_a;
    assign ex_b = (FWD_EN != 0 && wb_wr && exwb_rd == idex_rt) ? exwb_data : idex_b;

    always_comb begin
        ex_res = '0;
        case (idex_op)
            OP_ADD:  ex_res = ex_a + ex_b;
            OP_SUB:  ex_res = ex_a - ex_b;
            OP_AND:  ex_res = ex_a & ex_b;
            OP_OR:   ex_res = ex_a | ex_b;
            OP_NOT:  ex_res = ~ex_a;
            OP_LDI:  ex_res = idex_imm;
            OP_MOV:  ex_res = ex_a;
            OP_ADDI: ex_res = ex_a + idex_imm;
            default: ex_res = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        case (state)
            ST_IDLE, ST_HALTED: begin
                if (run) begin
                    state_nx = ST_RUN;
                    start    = 1'b1;
                end
            end
            ST_RUN: begin
                if (exwb_valid && exwb_hlt) state_nx = ST_HALTED;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Memory contents survive reset; only the loader port changes them.
    always_ff @(posedge clk) begin
        if (bus.imem_we && state != ST_RUN) imem[bus.imem_waddr] <= bus.imem_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= '0;
            fetch_stop <= 1'b0;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            idex_valid <= 1'b0;
            idex_we    <= 1'b0;
            idex_op    <= '0;
            idex_rd    <= '0;
            idex_rs    <= '0;
            idex_rt    <= '0;
            idex_a     <= '0;
            idex_b     <= '0;
            idex_imm   <= '0;
            exwb_valid <= 1'b0;
            exwb_we    <= 1'b0;
            exwb_hlt   <= 1'b0;
            exwb_rd    <= '0;
            exwb_data  <= '0;
            retired    <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (start) begin
            pc         <= '0;
            fetch_stop <= 1'b0;
            ifid_valid <= 1'b0;
            idex_valid <= 1'b0;
            exwb_valid <= 1'b0;
        end else if (state == ST_RUN) begin
            // A fetched HLT freezes pc on its own address; nothing behind it enters.
            if (!stall) begin
                if (fetch_stop) begin
                    ifid_valid <= 1'b0;
                end else begin
                    ifid_valid <= 1'b1;
                    ifid_instr <= fetch_word;
                    if (fetch_hlt) fetch_stop <= 1'b1;
                    else           pc <= pc + AW'(1);
                end
            end

            idex_valid <= ifid_valid && !stall;
            idex_we    <= op_writes(id_op);
            idex_op    <= id_op;
            idex_rd    <= id_rd;
            idex_rs    <= id_rs;
            idex_rt    <= id_rt;
            idex_a     <= id_a;
            idex_b     <= id_b;
            idex_imm   <= id_imm;

            exwb_valid <= idex_valid;
            exwb_we    <= idex_we;
            exwb_hlt   <= (idex_op == OP_HLT);
            exwb_rd    <= idex_rd;
            if (idex_valid) exwb_data <= ex_res;

            if (wb_wr)      regs[exwb_rd] <= exwb_data;
            if (exwb_valid) retired <= retired + 16'd1;
        end
    end

    assign bus.dbg_rdata = regs[bus.dbg_raddr];
    assign result        = exwb_data;
    assign result_valid  = exwb_valid && exwb_we;
    assign halted        = (state == ST_HALTED);

endmodule
